// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the DataMem arbiter: width-code bus and FSM state encodings.
// Optional fixed-priority mode is selected by DMEM_ARB_FIXED_PRI_EN in dmem_arbiter.sv.
`ifndef MEMWRWIDTH_BUS
`define MEMWRWIDTH_BUS 1:0
`endif

package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        DMEM_ARB_IDLE = 2'd0,
        DMEM_ARB_GNT0 = 2'd1,
        DMEM_ARB_GNT1 = 2'd2
    } dmem_arb_state_e;

    localparam logic RR_RESET = 1'b1;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port read response register: captures memory read data on a granted read
// and pulses rvalid for the following cycle; rdata holds until the next read.
module dmem_arb_resp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rvalid_d = cap;
        rdata_d  = rdata_q;
        if (cap) begin
            rdata_d = din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port DataMem, round-robin by default.
// Define DMEM_ARB_FIXED_PRI_EN for fixed priority with port 0 always winning.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [ADDR_W-1:0]      m0_addr,
    input  logic [DATA_W-1:0]      m0_wdata,
    input  logic [`MEMWRWIDTH_BUS] m0_width,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [DATA_W-1:0]      m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [ADDR_W-1:0]      m1_addr,
    input  logic [DATA_W-1:0]      m1_wdata,
    input  logic [`MEMWRWIDTH_BUS] m1_width,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [DATA_W-1:0]      m1_rdata,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_din,
    output logic [`MEMWRWIDTH_BUS] mem_width,
    input  logic [DATA_W-1:0]      mem_dout
);

    import dmem_arbiter_pkg::*;

    dmem_arb_state_e state_q, state_d;

`ifdef DMEM_ARB_FIXED_PRI_EN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DMEM_ARB_IDLE, DMEM_ARB_GNT0, DMEM_ARB_GNT1: begin
                if (m0_req) begin
                    state_d = DMEM_ARB_GNT0;
                end else if (m1_req && state_q != DMEM_ARB_GNT1) begin
                    state_d = DMEM_ARB_GNT1;
                end else begin
                    state_d = DMEM_ARB_IDLE;
                end
            end
            default: state_d = DMEM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DMEM_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic rr_last_q, rr_last_d;

    // rr_last names the port served most recently; the other one wins a tie
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            DMEM_ARB_IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = rr_last_q ? DMEM_ARB_GNT0 : DMEM_ARB_GNT1;
                end else if (m0_req) begin
                    state_d = DMEM_ARB_GNT0;
                end else if (m1_req) begin
                    state_d = DMEM_ARB_GNT1;
                end else begin
                    state_d = DMEM_ARB_IDLE;
                end
            end
            DMEM_ARB_GNT0: begin
                rr_last_d = 1'b0;
                state_d   = m1_req ? DMEM_ARB_GNT1 : DMEM_ARB_IDLE;
            end
            DMEM_ARB_GNT1: begin
                rr_last_d = 1'b1;
                state_d   = m0_req ? DMEM_ARB_GNT0 : DMEM_ARB_IDLE;
            end
            default: state_d = DMEM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= DMEM_ARB_IDLE;
            rr_last_q <= RR_RESET;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign m0_gnt = (state_q == DMEM_ARB_GNT0);
    assign m1_gnt = (state_q == DMEM_ARB_GNT1);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        mem_width = '0;
        unique case (state_q)
            DMEM_ARB_GNT0: begin
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_din   = m0_wdata;
                mem_width = m0_width;
            end
            DMEM_ARB_GNT1: begin
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_din   = m1_wdata;
                mem_width = m1_width;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    dmem_arb_resp #(.DATA_W(DATA_W)) u_resp0 (
        .clk    (clk),
        .rstn   (rstn),
        .cap    (m0_gnt && !m0_we),
        .din    (mem_dout),
        .rvalid (m0_rvalid),
        .rdata  (m0_rdata)
    );

    dmem_arb_resp #(.DATA_W(DATA_W)) u_resp1 (
        .clk    (clk),
        .rstn   (rstn),
        .cap    (m1_gnt && !m1_we),
        .din    (mem_dout),
        .rvalid (m1_rvalid),
        .rdata  (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed DataMem model.
// Covers reset, write/read, alternation, mid-access reset and the priority mode.
`ifndef MEMWRWIDTH_BUS
`define MEMWRWIDTH_BUS 1:0
`endif

module tb_dmem_arbiter;

    logic                   clk;
    logic                   rstn;
    logic                   m0_req, m0_we, m1_req, m1_we;
    logic [31:0]            m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [`MEMWRWIDTH_BUS] m0_width, m1_width, mem_width;
    logic                   m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]            m0_rdata, m1_rdata;
    logic                   mem_we;
    logic [31:0]            mem_addr, mem_din, mem_dout;
    logic [31:0]            mem [64];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_width  (m0_width),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_width  (m1_width),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_width (mem_width),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hC0DE_0000 | i;
        end
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_din;
        end
    end

    assign mem_dout = mem[mem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // per-cycle expectations while both ports request: {gnt0, gnt1, rv0, rv1}
    logic [3:0] both_tbl [5];

    initial begin
`ifdef DMEM_ARB_FIXED_PRI_EN
        both_tbl[0] = 4'b1000;
        both_tbl[1] = 4'b1010;
        both_tbl[2] = 4'b1010;
        both_tbl[3] = 4'b1010;
        both_tbl[4] = 4'b0010;
`else
        both_tbl[0] = 4'b1000;
        both_tbl[1] = 4'b0110;
        both_tbl[2] = 4'b1001;
        both_tbl[3] = 4'b0110;
        both_tbl[4] = 4'b0001;
`endif
    end

    initial begin
        rstn     = 1'b0;
        m0_req   = 1'b0;
        m0_we    = 1'b0;
        m0_addr  = '0;
        m0_wdata = '0;
        m0_width = 2'b10;
        m1_req   = 1'b0;
        m1_we    = 1'b0;
        m1_addr  = '0;
        m1_wdata = '0;
        m1_width = 2'b10;

        repeat (2) @(negedge clk);
        chk("rst_async_rdata0", m0_rdata, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_gnt0", {31'b0, m0_gnt}, 32'h0);
            chk("idle_gnt1", {31'b0, m1_gnt}, 32'h0);
            chk("idle_rv", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
            chk("idle_we", {31'b0, mem_we}, 32'h0);
            chk("idle_addr", mem_addr, 32'h0);
        end
        chk("idle_rdata1", m1_rdata, 32'h0);

        @(posedge clk); #1;
        m0_req   = 1'b1;
        m0_we    = 1'b1;
        m0_addr  = 32'h10;
        m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_pre_gnt", {31'b0, m0_gnt}, 32'h0);
        @(negedge clk);
        chk("wr_gnt0", {31'b0, m0_gnt}, 32'h1);
        chk("wr_gnt1", {31'b0, m1_gnt}, 32'h0);
        chk("wr_we", {31'b0, mem_we}, 32'h1);
        chk("wr_addr", mem_addr, 32'h10);
        chk("wr_din", mem_din, 32'hDEAD_BEEF);
        chk("wr_width", {30'b0, mem_width}, 32'h2);
        @(posedge clk); #1;
        m0_req = 1'b0;
        m0_we  = 1'b0;
        @(negedge clk);
        chk("wr_gnt_drop", {31'b0, m0_gnt}, 32'h0);
        chk("wr_no_rv_a", {31'b0, m0_rvalid}, 32'h0);
        @(negedge clk);
        chk("wr_no_rv_b", {31'b0, m0_rvalid}, 32'h0);

        @(posedge clk); #1;
        m1_req  = 1'b1;
        m1_we   = 1'b0;
        m1_addr = 32'h10;
        @(negedge clk);
        chk("rd_pre_gnt", {31'b0, m1_gnt}, 32'h0);
        @(negedge clk);
        chk("rd_gnt1", {31'b0, m1_gnt}, 32'h1);
        chk("rd_we", {31'b0, mem_we}, 32'h0);
        chk("rd_addr", mem_addr, 32'h10);
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        chk("rd_rv1", {31'b0, m1_rvalid}, 32'h1);
        chk("rd_rdata1", m1_rdata, 32'hDEAD_BEEF);
        chk("rd_rv0_quiet", {31'b0, m0_rvalid}, 32'h0);
        @(negedge clk);
        chk("rd_rv1_pulse", {31'b0, m1_rvalid}, 32'h0);
        chk("rd_rdata1_hold", m1_rdata, 32'hDEAD_BEEF);

        @(posedge clk); #1;
        m0_req  = 1'b1;
        m0_addr = 32'h10;
        m1_req  = 1'b1;
        m1_addr = 32'h20;
        @(negedge clk);
        chk("both_pre", {30'b0, m0_gnt, m1_gnt}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("both_gnt0", {31'b0, m0_gnt}, {31'b0, both_tbl[i][3]});
            chk("both_gnt1", {31'b0, m1_gnt}, {31'b0, both_tbl[i][2]});
            chk("both_rv0", {31'b0, m0_rvalid}, {31'b0, both_tbl[i][1]});
            chk("both_rv1", {31'b0, m1_rvalid}, {31'b0, both_tbl[i][0]});
            if (both_tbl[i][1]) begin
                chk("both_rdata0", m0_rdata, 32'hDEAD_BEEF);
            end
            if (both_tbl[i][0]) begin
                chk("both_rdata1", m1_rdata, 32'hC0DE_0008);
            end
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end

        @(posedge clk); #1;
        m1_req  = 1'b1;
        m1_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt1", {31'b0, m1_gnt}, 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_gnt1_drop", {31'b0, m1_gnt}, 32'h0);
        chk("mid_rv1_drop", {31'b0, m1_rvalid}, 32'h0);
        chk("mid_rdata1_clr", m1_rdata, 32'h0);
        chk("mid_rdata0_clr", m0_rdata, 32'h0);
        m0_req  = 1'b1;
        m0_addr = 32'h10;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", {31'b0, m0_gnt}, 32'h1);
        chk("post_rst_gnt1", {31'b0, m1_gnt}, 32'h0);
        chk("post_rst_rv1", {31'b0, m1_rvalid}, 32'h0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
